data_ram_pipe: RTL
==================

Name: data_ram_pipe

Overview:
Parametrised data memory for the RISC-V core. It succeeds the combinational data RAM and sits behind the MEM stage.
- One write port with per-byte strobes and one pipelined read port.
- Configurable read latency and a ready handshake.
- Automatic zero-initialisation sweep after reset.
- Out-of-range address detection.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
DEPTH, 1024, number of words.
ADDR_W, 10, word-address width; must satisfy 2^ADDR_W >= DEPTH.
RD_LAT, 1, read latency in cycles from accept to rvalid; legal values are 1 and 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
ce  in  1  chip enable; 0 blocks acceptance of new requests.
ready  out  1  high when requests can be accepted (init_done & ce).
init_done  out  1  high once the zero sweep is complete.
we  in  1  write request.
waddr  in  ADDR_W  write word address.
wdata  in  DATA_W  write data.
wstrb  in  DATA_W/8  byte-lane write strobes; bit i covers wdata[8i+7:8i].
re  in  1  read request.
raddr  in  ADDR_W  read word address.
rvalid  out  1  one-cycle pulse marking valid rdata/rerr.
rdata  out  DATA_W  read data.
rerr  out  1  read address was >= DEPTH; qualified by rvalid.
werr  out  1  registered; pulses the cycle after a write to an address >= DEPTH is accepted.

Behaviour:
- Reset (rst=1 at an edge): state <= INIT, sweep counter <= 0. ready, init_done, rvalid, rerr and werr are 0; rdata = 0.
  - All in-flight reads are discarded.
  - Reset mid-sweep or mid-read restarts the sweep from 0.
- INIT state:
  - Each cycle writes 0 to mem[cnt], then cnt <= cnt+1. This runs regardless of ce, we and re.
  - When cnt == DEPTH-1 has been written, move to RUN and set init_done <= 1. The sweep takes exactly DEPTH cycles after rst deasserts.
  - Requests presented during INIT are ignored; no rvalid, no werr.
- RUN state:
  - ready = ce. Nothing leaves RUN except rst.
  - Write accepted when we & ready. At the edge, for each i with wstrb[i]=1 and waddr < DEPTH, the byte lane i of mem[waddr] takes wdata byte i. Other lanes are unchanged.
  - wstrb = 0 is a legal no-op write.
  - waddr >= DEPTH: memory is untouched and werr = 1 in the next cycle.
  - Read accepted when re & ready. The array is sampled at the accept edge, so later writes never affect an accepted read.
  - Fully pipelined: one read accepted per cycle, no bubbles. Results return in order.
  - RD_LAT=1: rvalid/rdata appear in the cycle after accept. RD_LAT=2: one extra output register stage.
  - raddr >= DEPTH: rdata = 0, rerr = 1, rvalid pulses normally.
  - If no read is accepted, rvalid = 0. rdata holds its last value; rerr = 0.
- ce deasserted: no new acceptance. Reads already in the pipeline still complete and emit rvalid.
- Simultaneous read and write to the same in-range address: see Optional Feature. A read and write to different addresses are fully independent.

Optional Feature:
Macro DATA_RAM_BYPASS_EN.
- Defined: a same-cycle accepted read of the address being written returns the merged word. Strobed lanes come from wdata; other lanes come from the old mem contents.
- Not defined: that read returns the old mem contents (read-before-write). The write still takes effect for subsequent reads.
- All other behaviour is identical in both builds.

Test Plan:
(DATA_W=32, DEPTH=16, ADDR_W=5, RD_LAT=1 unless noted.)
- Init sweep: pulse rst, then hold re=1, raddr=3, ce=1.
  - Required: ready=0 and no rvalid for 16 cycles. init_done=1 on cycle 16.
  - The first read returns rdata=0x00000000 and rerr=0.
- Byte strobes: write addr 5 = 0xAABBCCDD with wstrb=1111, then 0x11223344 with wstrb=0101, then read addr 5.
  - Required: rdata=0xAA22CC44 one cycle after accept.
- Same-address collision: with mem[2]=0x0, accept we (addr 2, 0xDEADBEEF, wstrb=1111) and re (addr 2) in the same cycle.
  - Required: rdata=0xDEADBEEF with the macro; 0x00000000 without it.
- Back-to-back reads, RD_LAT=2: accept reads of addr 1, 2, 3 on consecutive cycles, holding 0x1, 0x2, 0x3.
  - Required: rvalid high for 3 consecutive cycles starting 2 cycles after the first accept, data 0x1, 0x2, 0x3.
- Out of range: accept write to addr 20, then read of addr 20.
  - Required: werr=1 the cycle after the write. The read gives rvalid=1, rerr=1, rdata=0.
  - A following read of addr 4 is unchanged.
- Reset mid-read plus ce gating:
  - Accept a read, then assert rst next cycle. Required: no rvalid and the sweep restarts.
  - After init, with ce=0 and re=1: ready=0 and no rvalid.

Source files
------------

// File: rtl/data_ram_pipe.sv
// ---------------------------------------------------------------------------
// data_ram_pipe
//   Data memory for the RISC-V core, sitting behind the MEM stage.
//   Word-addressed array with one byte-strobed write port and one pipelined
//   read port. After reset the array is zero-filled by an automatic sweep,
//   one word per cycle, before any request is accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   ce         chip enable; 0 blocks acceptance of new requests
//   ready      requests accepted this cycle (init_done & ce)
//   init_done  zero sweep complete
//   we/waddr/wdata/wstrb   write request, word address, data, byte strobes
//   re/raddr               read request, word address
//   rvalid     one-cycle pulse qualifying rdata/rerr
//   rdata      read data (holds its last value between reads)
//   rerr       read address was >= DEPTH
//   werr       pulses the cycle after an accepted write to an address >= DEPTH
//
// Build option
//   DATA_RAM_BYPASS_EN : when defined, a read accepted in the same cycle as a
//   write to the same in-range address returns the merged word (strobed
//   lanes from wdata). When undefined the read returns the old contents.
// ---------------------------------------------------------------------------
module data_ram_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  output logic                ready,
  output logic                init_done,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                rerr,
  output logic                werr
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              werr_q;

  logic              wr_acc_s, rd_acc_s;
  logic              waddr_ok_s, raddr_ok_s;
  logic              wr_in_s;
  logic [DATA_W-1:0] rd_word_s;

  // first read stage: array sampled at the accept edge
  logic              rv1_q, rerr1_q;
  logic [DATA_W-1:0] rdata1_q;

  assign ready      = init_done_q & ce;
  assign init_done  = init_done_q;
  assign werr       = werr_q;

  // Address range checks; upper bits are kept so DEPTH < 2^ADDR_W is caught.
  assign waddr_ok_s = ({1'b0, waddr} < DEPTH_L);
  assign raddr_ok_s = ({1'b0, raddr} < DEPTH_L);
  assign wr_acc_s   = we & ready;
  assign rd_acc_s   = re & ready;
  assign wr_in_s    = wr_acc_s & waddr_ok_s;

  // Sweep / run state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= {ADDR_W{1'b0}};
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state logic: sweep DEPTH words, then stay in RUN until reset
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          cnt_d       = {ADDR_W{1'b0}};
        end else begin
          cnt_d       = cnt_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d     = ST_INIT;
        cnt_d       = {ADDR_W{1'b0}};
        init_done_d = 1'b0;
      end
    endcase
  end

  // Memory array: zero sweep during INIT, byte-strobed writes in RUN.
  // A write that coincides with a reset edge is harmless: the sweep that
  // follows overwrites every word.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q[IDX_W-1:0]] <= {DATA_W{1'b0}};
    end else if (wr_in_s) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) begin
          mem_q[waddr[IDX_W-1:0]][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read word selection; out-of-range reads return zero
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    if (raddr_ok_s) begin
      rd_word_s = mem_q[raddr[IDX_W-1:0]];
`ifdef DATA_RAM_BYPASS_EN
      // forward strobed lanes of a same-cycle write to the same word
      for (int i = 0; i < NB; i++) begin
        if (wr_in_s && (waddr == raddr) && wstrb[i]) begin
          rd_word_s[8*i +: 8] = wdata[8*i +: 8];
        end else begin
          rd_word_s[8*i +: 8] = mem_q[raddr[IDX_W-1:0]][8*i +: 8];
        end
      end
`endif
    end else begin
      rd_word_s = {DATA_W{1'b0}};
    end
  end

  // Write error flag, one cycle after an accepted out-of-range write
  always_ff @(posedge clk) begin
    if (rst) begin
      werr_q <= 1'b0;
    end else begin
      werr_q <= wr_acc_s & ~waddr_ok_s;
    end
  end

  // First read stage; data only updates on an accepted read so it holds
  always_ff @(posedge clk) begin
    if (rst) begin
      rv1_q    <= 1'b0;
      rerr1_q  <= 1'b0;
      rdata1_q <= {DATA_W{1'b0}};
    end else begin
      rv1_q    <= rd_acc_s;
      rerr1_q  <= rd_acc_s & ~raddr_ok_s;
      if (rd_acc_s) begin
        rdata1_q <= rd_word_s;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              rv2_q, rerr2_q;
      logic [DATA_W-1:0] rdata2_q;

      // Extra output register stage for RD_LAT=2
      always_ff @(posedge clk) begin
        if (rst) begin
          rv2_q    <= 1'b0;
          rerr2_q  <= 1'b0;
          rdata2_q <= {DATA_W{1'b0}};
        end else begin
          rv2_q    <= rv1_q;
          rerr2_q  <= rerr1_q;
          if (rv1_q) begin
            rdata2_q <= rdata1_q;
          end
        end
      end

      assign rvalid = rv2_q;
      assign rerr   = rerr2_q;
      assign rdata  = rdata2_q;
    end else begin : g_lat1
      assign rvalid = rv1_q;
      assign rerr   = rerr1_q;
      assign rdata  = rdata1_q;
    end
  endgenerate

endmodule
